// File: rtl/act_lut_interp_if.sv
// act_lut_interp_if: streaming and LUT-read signals of the activation
// interpolator, bundled for one port.
//   in_valid/in_ready/x        : pre-activation input stream
//   address/base/next__data    : LUT read (address out, two entries back)
//   out_valid/out_ready/y      : interpolated activation output stream
// Modports:
//   slave  - the interpolator block
//   master - the surrounding logic (neuron, LUT, next layer)
interface act_lut_interp_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] x;
   logic        [ADDR_W-1:0] address;
   logic signed [DATA_W-1:0] base;
   logic signed [DATA_W-1:0] next__data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] y;

   modport slave (
      input  in_valid, x, base, next__data, out_ready,
      output in_ready, address, out_valid, y
   );

   modport master (
      output in_valid, x, base, next__data, out_ready,
      input  in_ready, address, out_valid, y
   );
endinterface

// File: rtl/act_lut_interp.sv
// act_lut_interp: two-stage pipelined linear interpolation of an activation
// LUT. The upper ADDR_W bits of x select the LUT entry pair (base, next),
// the lower FRAC_W bits interpolate between them; the result is saturated
// to the signed DATA_W range.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - act_lut_interp_if.slave (input stream, LUT read, output stream)
// Build option:
//   ACT_LUT_INTERP_ROUND_EN - round-half-up interpolation instead of floor
module act_lut_interp #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input logic             clk,
   input logic             rst,
   act_lut_interp_if.slave bus
);
   localparam int unsigned FRAC_W = DATA_W - ADDR_W;
   localparam int unsigned PW     = DATA_W + FRAC_W + 2;

   localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);
`ifdef ACT_LUT_INTERP_ROUND_EN
   localparam logic signed [PW-1:0] HALF    = PW'(1) << (FRAC_W - 1);
`endif

   logic                     s1_valid;
   logic        [DATA_W-1:0] s1_x;
   logic                     s2_valid;
   logic signed [DATA_W-1:0] s2_base;
   logic signed [DATA_W-1:0] s2_next;
   logic        [FRAC_W-1:0] s2_frac;

   logic s1_adv;
   logic accept;

   // S2 frees up when empty or when its item is taken this cycle; S1 can
   // refill in the same cycle it drains, giving one item per cycle.
   assign s1_adv       = !s2_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || s1_adv;
   assign accept       = bus.in_valid && bus.in_ready;

   // The LUT is addressed from the S1 register so base/next arrive in time
   // for the S2 capture.
   assign bus.address   = s1_x[DATA_W-1:FRAC_W];
   assign bus.out_valid = s2_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s2_valid <= 1'b0;
         s2_base  <= '0;
         s2_next  <= '0;
         s2_frac  <= '0;
      end else begin
         if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_base <= bus.base;
               s2_next <= bus.next__data;
               s2_frac <= s1_x[FRAC_W-1:0];
            end
         end
         if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (accept) begin
               s1_x <= bus.x;
            end
         end
      end
   end

   logic signed [PW-1:0]     base_w;
   logic signed [PW-1:0]     next_w;
   logic signed [PW-1:0]     frac_w;
   logic signed [PW-1:0]     prod;
   logic signed [PW-1:0]     corr;
   logic signed [PW-1:0]     sum;
   logic signed [DATA_W-1:0] y_c;

   // Everything is widened to PW bits up front: the difference needs one
   // extra bit and the product FRAC_W more, so no intermediate can wrap.
   always_comb begin
      base_w = {{(PW - DATA_W){s2_base[DATA_W-1]}}, s2_base};
      next_w = {{(PW - DATA_W){s2_next[DATA_W-1]}}, s2_next};
      frac_w = {{(PW - FRAC_W){1'b0}}, s2_frac};
      prod   = (next_w - base_w) * frac_w;
`ifdef ACT_LUT_INTERP_ROUND_EN
      corr   = (prod + HALF) >>> FRAC_W;
`else
      corr   = prod >>> FRAC_W;
`endif
      sum    = base_w + corr;
      if (sum > SAT_MAX) begin
         y_c = {1'b0, {(DATA_W - 1){1'b1}}};
      end else if (sum < SAT_MIN) begin
         y_c = {1'b1, {(DATA_W - 1){1'b0}}};
      end else begin
         y_c = sum[DATA_W-1:0];
      end
   end

   assign bus.y = y_c;
endmodule

// File: doc/act_lut_interp.md
Name: act_lut_interp

Overview:
- Consumer end of the activation-LUT read interface (address → base, next__data).
- Takes a signed fixed-point pre-activation x, drives the LUT address from the upper bits, and receives base and next__data combinationally.
- Linearly interpolates between the two entries using the lower bits of x.
- Sits between a neuron's accumulator output and the next layer's input. Pipelined, with valid/ready on both sides.

Parameters:
- DATA_W, 8, width of x, LUT entries and y (signed two's complement).
- ADDR_W, 4, LUT address width.
- Derived, not overridable: FRAC_W = DATA_W − ADDR_W, the interpolation fraction width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  x is valid.
- in_ready  out  1  block accepts x this cycle.
- x  in  DATA_W  signed pre-activation.
- address  out  ADDR_W  LUT index, equal to s1_x[DATA_W-1:FRAC_W].
- base  in  DATA_W  signed LUT[address].
- next__data  in  DATA_W  signed neighbouring entry supplied by the LUT, including its own wrap/clamp.
- out_valid  out  1  y is valid.
- out_ready  in  1  downstream accepts y.
- y  out  DATA_W  signed interpolated activation.

Behaviour:
- Reset (rst=0, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, y=0, address=0, all pipeline registers 0. in_ready is 1 from the first cycle after deassertion.
- Reset mid-operation: in-flight data is discarded; no out_valid pulse follows.
- Stage 1 (S1):
  - Accept when in_valid && in_ready; register x into s1_x and set s1_valid.
  - address is driven from s1_x only, never combinationally from x.
- Stage 2 (S2):
  - When S1 advances, capture s2_base=base, s2_next=next__data, s2_frac=s1_x[FRAC_W-1:0].
  - Compute y from the registered values. y and out_valid are outputs of S2 registers.
- Arithmetic:
  - diff = next − base, DATA_W+1 bits signed.
  - prod = diff × {0,frac}, signed, DATA_W+FRAC_W+2 bits.
  - corr = prod >>> FRAC_W (arithmetic shift, floor).
  - sum = base + corr, DATA_W+1 bits.
  - y = sum saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Latency: out_valid rises exactly 2 cycles after the accepting edge when out_ready=1 throughout. Throughput is 1 per cycle.
- Handshake and stall:
  - S2 holds (y and out_valid stable) while out_valid && !out_ready.
  - S1 advances iff !s2_valid || out_ready.
  - in_ready = !s1_valid || S1 advances.
  - With out_ready=0, at most 2 items are held before in_ready drops. No loss, no duplication, order preserved.
- Simultaneous events: accept into S1 and pop from S2 in the same cycle is legal and keeps full throughput.
- Boundary cases:
  - address 2^(ADDR_W−1)−1: the LUT returns next==base; the block must not special-case it.
  - address 2^ADDR_W−1 wraps to entry 0. This is handled by the LUT, not here.
  - x and in_valid are don't-care while in_ready=0 and no accept occurs.

Optional Feature:
- Macro: ACT_LUT_INTERP_ROUND_EN.
- Defined: corr = (prod + 2^(FRAC_W−1)) >>> FRAC_W (round half up). Saturation is unchanged.
- Undefined: floor as specified above. Latency and handshake are identical in both builds.

Test Plan:
- Bench LUT model: entry i = 16·i for i<8, 16·i−256 for i≥8. next__data = lut[0] at address 15, lut[7] at address 7, otherwise lut[address+1].
- x=0x35, out_ready=1 → address=3, y=53, out_valid exactly 2 cycles after accept.
- x=0x7F → y=112 (clamp entry). x=0xFF → y=−1 (wrap entry, −16+15). x=0x80 → y=−128.
- Stream 0x10,0x20,0x30 back-to-back with out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepts; y holds 16.
  - On release, y=16,32,48 in order, one per cycle.
- Custom LUT (base=0, next=1), x frac=8:
  - y=0 without ACT_LUT_INTERP_ROUND_EN.
  - y=1 with it.
  - base=127, next=−128, frac=15 → no wrap, y within range, saturation not tripped.
- Assert rst for 1 cycle with both stages full → out_valid=0 and y=0 immediately. No stale output after release; the next input yields its correct value.
